// File: rtl/mem_read_data_decoder_if.sv
// Handshake and data bus of the load-data decoder: request side, memory side, result side.
interface mem_read_data_decoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  offset;
  logic [1:0]  data_size;
  logic        sign_ext;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  err_code;

  modport master (
    output req_valid, offset, data_size, sign_ext, mem_rd_data, mem_rd_valid, out_ready,
    input  req_ready, mem_rd_en, out_data, out_valid, err_code
  );

  modport slave (
    input  req_valid, offset, data_size, sign_ext, mem_rd_data, mem_rd_valid, out_ready,
    output req_ready, mem_rd_en, out_data, out_valid, err_code
  );
endinterface

// File: rtl/mem_read_data_decoder.sv
// Load-data decoder: issues one memory read, waits with timeout, then returns the
// lane-selected, sign/zero-extended result with an error code.
module mem_read_data_decoder #(
  parameter int MAX_WAIT = 15
) (
  input logic                     clk,
  input logic                     rst,
  mem_read_data_decoder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] off_q;
  logic [1:0] size_q;
  logic       sext_q;

  // Byte lane 0 sits in bits 31:24 (big-endian lane numbering).
  function automatic logic [31:0] lane_decode(logic [31:0] d, logic [1:0] off,
                                              logic [1:0] sz, logic sx);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = off[1] ? d[15:0] : d[31:16];
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    case (sz)
      2'b00:   r = d;
      2'b01:   r = {{16{sx & h[15]}}, h};
      default: r = {{24{sx & b[7]}}, b};
    endcase
    return r;
  endfunction

  logic illegal;
  assign illegal = (bus.data_size == 2'b11) || (bus.data_size == 2'b01 && bus.offset[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      off_q         <= '0;
      size_q        <= '0;
      sext_q        <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.mem_rd_en <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.err_code  <= 2'b00;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          off_q         <= bus.offset;
          size_q        <= bus.data_size;
          sext_q        <= bus.sign_ext;
          bus.req_ready <= 1'b0;
          if (illegal) begin
            state         <= RESP;
            bus.out_valid <= 1'b1;
            bus.out_data  <= '0;
            bus.err_code  <= 2'b01;
          end else begin
            state         <= REQ;
            bus.mem_rd_en <= 1'b1;
          end
        end
        REQ: begin
          state         <= WAIT;
          bus.mem_rd_en <= 1'b0;
          cnt           <= '0;
        end
        WAIT: begin
          // A response arriving on the final wait cycle still counts as success.
          if (bus.mem_rd_valid) begin
            state         <= RESP;
            bus.out_valid <= 1'b1;
            bus.out_data  <= lane_decode(bus.mem_rd_data, off_q, size_q, sext_q);
            bus.err_code  <= 2'b00;
          end else if (cnt == LAST_WAIT) begin
            state         <= RESP;
            bus.out_valid <= 1'b1;
            bus.out_data  <= '0;
            bus.err_code  <= 2'b10;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: if (bus.out_ready) begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.out_valid <= 1'b0;
          bus.out_data  <= '0;
          bus.err_code  <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_data_decoder.sv
// Transaction-level bench for mem_read_data_decoder: directed corner cases plus
// randomized loads checked against an arithmetic lane/extension model.
module tb_mem_read_data_decoder;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mem_read_data_decoder_if bus();

  mem_read_data_decoder #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(logic [31:0] d, logic [1:0] off,
                                           logic [1:0] sz, logic sx);
    int w, sh;
    logic [31:0] m, f;
    if (sz == 2'b00) return d;
    w  = (sz == 2'b01) ? 16 : 8;
    sh = (sz == 2'b01) ? (off[1] ? 0 : 16) : 8 * (3 - int'(off));
    m  = (32'h1 << w) - 32'h1;
    f  = (d >> sh) & m;
    if (sx && f[w-1]) f = f | ~m;
    return f;
  endfunction

  // rd_delay: 0-based WAIT cycle on which data arrives (<0 or >=MAX_WAIT: never).
  task automatic run_txn(logic [1:0] off, logic [1:0] sz, logic sx, logic [31:0] d,
                         int rd_delay, int rdy_delay, bit stray);
    logic [1:0]  eerr;
    logic [31:0] eres;
    int exp_cyc, pulses;
    bit legal, seen;
    legal = !(sz == 2'b11 || (sz == 2'b01 && off[0]));
    if (!legal) begin
      eerr = 2'b01; eres = '0; exp_cyc = 1;
    end else if (rd_delay >= 0 && rd_delay < MAX_WAIT) begin
      eerr = 2'b00; eres = ref_load(d, off, sz, sx); exp_cyc = 3 + rd_delay;
    end else begin
      eerr = 2'b10; eres = '0; exp_cyc = 2 + MAX_WAIT;
    end

    @(negedge clk);
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.offset = off; bus.data_size = sz; bus.sign_ext = sx;
    pulses = 0; seen = 0;
    for (int c = 1; c <= exp_cyc + 2 && !seen; c++) begin
      @(negedge clk);
      bus.req_valid = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.offset = 2'($urandom); bus.data_size = 2'($urandom); bus.sign_ext = 1'($urandom);
      if (bus.mem_rd_en) pulses++;
      if (bus.out_valid) begin
        seen = 1;
        chk("latency", 32'(c), 32'(exp_cyc));
        chk("out_data", bus.out_data, eres);
        chk("err_code", 32'(bus.err_code), 32'(eerr));
        bus.mem_rd_valid = stray;
        bus.mem_rd_data  = $urandom;
        bus.out_ready    = (rdy_delay == 0);
      end else begin
        chk("quiet_data", bus.out_data, 32'd0);
        chk("quiet_err", 32'(bus.err_code), 32'd0);
        bus.mem_rd_valid = (c - 2 == rd_delay) || (stray && c == 1);
        bus.mem_rd_data  = (c - 2 == rd_delay) ? d : $urandom;
      end
    end
    if (!seen) chk("out_valid_missing", 32'd0, 32'd1);

    for (int i = 0; i < rdy_delay; i++) begin
      @(negedge clk);
      if (bus.mem_rd_en) pulses++;
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_data", bus.out_data, eres);
      chk("hold_err", 32'(bus.err_code), 32'(eerr));
      bus.req_valid    = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.mem_rd_valid = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.out_ready    = (i == rdy_delay - 1);
    end
    chk("rd_en_pulses", 32'(pulses), 32'(legal));

    @(negedge clk);
    chk("done_valid", 32'(bus.out_valid), 32'd0);
    chk("done_data", bus.out_data, 32'd0);
    chk("done_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b0; bus.mem_rd_valid = 1'b0; bus.out_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0; bus.offset = '0; bus.data_size = '0; bus.sign_ext = 1'b0;
    bus.mem_rd_data = '0; bus.mem_rd_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_err", 32'(bus.err_code), 32'd0);

    run_txn(2'd2, 2'b00, 1'b0, 32'h12345678, 3, 0, 0);
    run_txn(2'd2, 2'b00, 1'b0, 32'h12345678, 0, 1, 0);
    run_txn(2'd1, 2'b10, 1'b1, 32'h00F00000, 1, 0, 0);
    run_txn(2'd1, 2'b10, 1'b0, 32'h00F00000, 1, 0, 0);
    run_txn(2'd2, 2'b01, 1'b1, 32'h00008001, 2, 0, 0);
    run_txn(2'd1, 2'b01, 1'b1, 32'h00008001, 0, 0, 0);
    run_txn(2'd0, 2'b11, 1'b0, 32'hDEADBEEF, 0, 2, 1);
    run_txn(2'd0, 2'b00, 1'b0, 32'hCAFEF00D, -1, 0, 0);
    run_txn(2'd3, 2'b10, 1'b1, 32'h000000FF, 3, 0, 0);
    run_txn(2'd0, 2'b01, 1'b0, 32'hA5A55A5A, 1, 5, 1);

    // Reset while waiting for memory: nothing may be delivered afterwards.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.offset = 2'd0; bus.data_size = 2'b00; bus.sign_ext = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.mem_rd_valid = 1'b1; bus.mem_rd_data = 32'h11223344;
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_rd_en", 32'(bus.mem_rd_en), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_rd_valid = 1'b0;
      chk("abort_no_valid", 32'(bus.out_valid), 32'd0);
    end

    for (int n = 0; n < 60; n++)
      run_txn(2'($urandom), 2'($urandom), 1'($urandom), $urandom,
              $urandom_range(0, MAX_WAIT + 1) - 1, $urandom_range(0, 3),
              1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_read_data_decoder.md
MEM_READ_DATA_DECODER -- requirements
Module: mem_read_data_decoder

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum WAIT-state cycles before timeout; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  load request present.
REQ-005 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 offset  input  2  low two bits of the physical address.
REQ-007 data_size  input  2  00 word, 01 halfword, 10 byte, 11 illegal.
REQ-008 sign_ext  input  1  1 sign-extends halfword/byte results, 0 zero-extends them.
REQ-009 mem_rd_en  output  1  one-cycle read strobe to data memory.
REQ-010 mem_rd_data  input  32  raw word returned by data memory.
REQ-011 mem_rd_valid  input  1  mem_rd_data valid this cycle.
REQ-012 out_data  output  32  aligned, extended load result.
REQ-013 out_valid  output  1  result and err_code valid.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 err_code  output  2  00 ok, 01 misaligned/illegal size, 10 timeout.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, RESP.
REQ-017 IDLE: req_ready=1; on req_valid=1, latch offset, data_size and sign_ext.
REQ-018 Illegal request (data_size=11, or halfword with offset 01/11): go to RESP with err_code=01 and out_data=0; mem_rd_en is never asserted.
REQ-019 Word requests ignore offset and are always legal.
REQ-020 Legal request: IDLE->REQ; mem_rd_en=1 for exactly the one REQ cycle; REQ->WAIT unconditionally.
REQ-021 WAIT: wait counter starts at 0 and increments each cycle; mem_rd_valid is sampled only in WAIT.
REQ-022 WAIT with mem_rd_valid=1: decode mem_rd_data, register it into out_data with err_code=00, go to RESP.
REQ-023 WAIT timeout: when counter=MAX_WAIT-1 and mem_rd_valid=0, go to RESP with err_code=10 and out_data=0.
REQ-024 mem_rd_valid=1 on the timeout cycle SHALL win: treated as a normal completion.
REQ-025 Lane mapping (byte lane 0 = bits 31:24):
- Word: out_data=mem_rd_data.
- Halfword offset 00 -> bits 31:16; offset 10 -> bits 15:0.
- Byte offset 00 -> 31:24; 01 -> 23:16; 10 -> 15:8; 11 -> 7:0.
REQ-026 Extension: halfword/byte results are placed in the low bits; upper bits are filled with the selected field's MSB if sign_ext=1, else zeros.
REQ-027 RESP: out_valid=1 and out_data/err_code held stable until out_ready=1; that cycle RESP->IDLE.
REQ-028 out_data=0 and err_code=00 whenever out_valid=0.
REQ-029 mem_rd_valid in IDLE, REQ or RESP SHALL be ignored, with no state change.
REQ-030 req_valid outside IDLE SHALL be ignored; no request queuing.
REQ-031 Latency: request accepted at edge N -> mem_rd_en high in cycle N+1 -> earliest mem_rd_valid in cycle N+2 -> out_valid in cycle N+3.
REQ-032 Latency for an illegal request: out_valid high in the cycle after acceptance.

Reset
REQ-033 rst=1 at a rising edge SHALL force IDLE, clear the counter and latched fields, and set mem_rd_en=0, out_valid=0, out_data=0, err_code=00, req_ready=1 in the following cycle.
REQ-034 Reset in REQ/WAIT/RESP aborts the operation; no result is delivered, and a later mem_rd_valid is ignored.

Verification
REQ-035 Word load offset 10, mem_rd_data=0x12345678 after 3 WAIT cycles -> mem_rd_en exactly one pulse; out_data=0x12345678, err_code=00.
REQ-036 Byte offset 01, sign_ext=1, data=0x00F00000 -> out_data=0xFFFFFFF0; same with sign_ext=0 -> 0x000000F0.
REQ-037 Halfword offset 10, sign_ext=1, data=0x0000_8001 -> out_data=0xFFFF8001; halfword offset 01 -> err_code=01, out_data=0, no mem_rd_en.
REQ-038 MAX_WAIT=4, mem_rd_valid never asserted -> out_valid 4 cycles after entering WAIT with err_code=10; mem_rd_valid on the 4th WAIT cycle -> err_code=00.
REQ-039 out_ready held low 5 cycles in RESP -> out_valid/out_data stable; req_valid pulses ignored until IDLE.
REQ-040 rst asserted in WAIT, mem_rd_valid pulsed next cycle -> out_valid stays 0; req_ready=1 after reset.
